urv_mult_pipe: RTL and testbench

//  Parametrised, pipelined RV32M/RV64M-style integer multiplier for the uRV execute/writeback path.

---
 rtl/urv_mult_pipe.sv | 162 ++++++++++++++++
 tb/tb_urv_mult_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/urv_mult_pipe.sv
// Pipelined RV32M/RV64M multiplier with tagged, in-order writeback.
// Macro URV_MULH_EN enables MULH/MULHSU/MULHU (the full 2*WIDTH-bit product).
module urv_mult_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             d_valid_i,
    input  logic [WIDTH-1:0] d_rs1_i,
    input  logic [WIDTH-1:0] d_rs2_i,
    input  logic [2:0]       d_fun_i,
    input  logic [TAG_W-1:0] d_tag_i,
    output logic             w_valid_o,
    output logic [WIDTH-1:0] w_rd_o,
    output logic [TAG_W-1:0] w_tag_o,
    output logic             busy_o
);

`ifdef URV_MULH_EN
    localparam int XW = WIDTH + 1;
`else
    localparam int XW = WIDTH;
`endif

    logic                    rsv;
    logic                    hi;
    logic                    zero;
    logic signed [XW-1:0]    a_x;
    logic signed [XW-1:0]    b_x;
    logic                    ld0;

    logic                    s1_v;
    logic signed [XW-1:0]    s1_a;
    logic signed [XW-1:0]    s1_b;
    logic                    s1_zero;
    logic [TAG_W-1:0]        s1_tag;
`ifdef URV_MULH_EN
    logic                    s1_hi;
    logic                    sa;
    logic                    sb;
    logic signed [2*WIDTH-1:0] prod;
`else
    logic [WIDTH-1:0]        prod;
`endif
    logic [WIDTH-1:0]        res;

    always_comb begin
        rsv = d_fun_i[2];
        hi  = !d_fun_i[2] && (d_fun_i[1:0] != 2'b00);
`ifdef URV_MULH_EN
        sa   = (d_fun_i == 3'b001) || (d_fun_i == 3'b010);
        sb   = (d_fun_i == 3'b001);
        a_x  = {sa & d_rs1_i[WIDTH-1], d_rs1_i};
        b_x  = {sb & d_rs2_i[WIDTH-1], d_rs2_i};
        zero = rsv;
`else
        a_x  = d_rs1_i;
        b_x  = d_rs2_i;
        // high-half ops still flow through the pipe, but yield zero
        zero = rsv | hi;
`endif
    end

    assign ld0 = d_valid_i & ~stall_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_v    <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_zero <= 1'b0;
            s1_tag  <= '0;
`ifdef URV_MULH_EN
            s1_hi   <= 1'b0;
`endif
        end else begin
            if (flush_i)
                s1_v <= 1'b0;
            else if (!stall_i)
                s1_v <= d_valid_i;
            if (ld0) begin
                s1_a    <= a_x;
                s1_b    <= b_x;
                s1_zero <= zero;
                s1_tag  <= d_tag_i;
`ifdef URV_MULH_EN
                s1_hi   <= hi;
`endif
            end
        end
    end

    always_comb begin
`ifdef URV_MULH_EN
        prod = (2*WIDTH)'(s1_a) * (2*WIDTH)'(s1_b);
        if (s1_zero)
            res = '0;
        else if (s1_hi)
            res = prod[2*WIDTH-1:WIDTH];
        else
            res = prod[WIDTH-1:0];
`else
        prod = s1_a * s1_b;
        res  = s1_zero ? '0 : prod;
`endif
    end

    // result chain; the last entry is the writeback register
    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] c_v;
    logic [WIDTH-1:0]   r_q [LATENCY];
    logic [WIDTH-1:0]   c_r [LATENCY];
    logic [TAG_W-1:0]   t_q [LATENCY];
    logic [TAG_W-1:0]   c_t [LATENCY];

    always_comb begin
        c_v = '0;
        for (int i = 0; i < LATENCY; i++) begin
            c_r[i] = '0;
            c_t[i] = '0;
        end
        c_v[0] = s1_v;
        c_r[0] = res;
        c_t[0] = s1_tag;
        for (int i = 1; i < LATENCY; i++) begin
            c_v[i] = v_q[i-1];
            c_r[i] = r_q[i-1];
            c_t[i] = t_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_q[i] <= '0;
                t_q[i] <= '0;
            end
        end else begin
            if (flush_i)
                v_q <= '0;
            else if (!stall_i)
                v_q <= c_v;
            for (int i = 0; i < LATENCY; i++) begin
                if (c_v[i] && !stall_i && !flush_i) begin
                    r_q[i] <= c_r[i];
                    t_q[i] <= c_t[i];
                end
            end
        end
    end

    assign w_valid_o = v_q[LATENCY-1];
    assign w_rd_o    = r_q[LATENCY-1];
    assign w_tag_o   = t_q[LATENCY-1];
    assign busy_o    = s1_v | (|v_q);

endmodule

// File: tb/tb_urv_mult_pipe.sv
// Directed bench for urv_mult_pipe (WIDTH=32, LATENCY=2).
// Expected high-half results follow URV_MULH_EN as seen by this compile.
module tb_urv_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        d_valid = 1'b0;
    logic [31:0] d_rs1 = '0;
    logic [31:0] d_rs2 = '0;
    logic [2:0]  d_fun = '0;
    logic [4:0]  d_tag = '0;
    logic        w_valid;
    logic [31:0] w_rd;
    logic [4:0]  w_tag;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    urv_mult_pipe #(.WIDTH(32), .LATENCY(2), .TAG_W(5)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
        .d_valid_i(d_valid), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2),
        .d_fun_i(d_fun), .d_tag_i(d_tag),
        .w_valid_o(w_valid), .w_rd_o(w_rd), .w_tag_o(w_tag), .busy_o(busy)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  fun;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] expv(input vec_t v);
`ifdef URV_MULH_EN
        return v.exp;
`else
        if (!v.fun[2] && v.fun[1:0] != 2'b00)
            return 32'h0;
        return v.exp;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f,
                       input logic [4:0] t);
        d_valid = v;
        d_rs1   = a;
        d_rs2   = b;
        d_fun   = f;
        d_tag   = t;
    endtask

    initial begin
        vt[0]  = '{32'h0001_0003, 32'h0000_0005, 3'b000, 5'd1,  32'h0005_000F};
        vt[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 5'd2,  32'h0000_0000};
        vt[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd3,  32'hFFFF_FFFE};
        vt[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 5'd4,  32'hFFFF_FFFF};
        vt[4]  = '{32'h8000_0000, 32'h8000_0000, 3'b001, 5'd5,  32'h4000_0000};
        vt[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 5'd6,  32'h0000_0001};
        vt[6]  = '{32'h0000_0007, 32'h0000_0009, 3'b100, 5'd7,  32'h0000_0000};
        vt[7]  = '{32'h8000_0000, 32'h0000_0002, 3'b011, 5'd8,  32'h0000_0001};
        vt[8]  = '{32'h1234_5678, 32'h0000_0010, 3'b000, 5'd9,  32'h2345_6780};
        vt[9]  = '{32'h8000_0000, 32'h8000_0000, 3'b010, 5'd10, 32'hC000_0000};
        vt[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b001, 5'd11, 32'h3FFF_FFFF};
        vt[11] = '{32'hFFFF_FFFE, 32'h0000_0003, 3'b001, 5'd12, 32'hFFFF_FFFF};

        // reset state
        #12;
        chk("rst_valid", 32'(w_valid), 32'h0);
        chk("rst_rd", w_rd, 32'h0);
        chk("rst_tag", 32'(w_tag), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        step;
        rst_n = 1'b1;
        step;

        // streamed vectors, one per cycle; result appears two edges later
        for (int i = 0; i < 14; i++) begin
            if (i < 12)
                put(1'b1, vt[i].rs1, vt[i].rs2, vt[i].fun, vt[i].tag);
            else
                put(1'b0, '0, '0, 3'b000, '0);
            step;
            if (i >= 2) begin
                chk($sformatf("v%0d_valid", i-2), 32'(w_valid), 32'h1);
                chk($sformatf("v%0d_tag", i-2), 32'(w_tag), 32'(vt[i-2].tag));
                chk($sformatf("v%0d_rd", i-2), w_rd, expv(vt[i-2]));
            end else begin
                chk($sformatf("lead%0d_valid", i), 32'(w_valid), 32'h0);
            end
        end
        chk("stream_busy_last", 32'(busy), 32'h1);
        step;
        chk("stream_done_valid", 32'(w_valid), 32'h0);
        chk("stream_done_busy", 32'(busy), 32'h0);

        // stall: accepted at edge 0, stalled edges 1..3
        put(1'b1, 32'd3, 32'd4, 3'b000, 5'd20);
        step;
        stall = 1'b1;
        put(1'b1, 32'd9, 32'd9, 3'b000, 5'd21);
        for (int e = 1; e <= 3; e++) begin
            step;
            chk($sformatf("stall_e%0d_valid", e), 32'(w_valid), 32'h0);
            chk($sformatf("stall_e%0d_busy", e), 32'(busy), 32'h1);
        end
        stall = 1'b0;
        put(1'b0, '0, '0, 3'b000, '0);
        step;
        chk("stall_e4_valid", 32'(w_valid), 32'h0);
        step;
        chk("stall_e5_valid", 32'(w_valid), 32'h1);
        chk("stall_e5_rd", w_rd, 32'd12);
        chk("stall_e5_tag", 32'(w_tag), 32'd20);
        stall = 1'b1;
        step;
        chk("held_valid", 32'(w_valid), 32'h1);
        chk("held_rd", w_rd, 32'd12);
        chk("held_tag", 32'(w_tag), 32'd20);
        stall = 1'b0;
        step;
        chk("held_release_valid", 32'(w_valid), 32'h0);
        for (int e = 0; e < 3; e++) begin
            step;
            chk($sformatf("stall_tail%0d_valid", e), 32'(w_valid), 32'h0);
        end
        chk("stall_tail_busy", 32'(busy), 32'h0);

        // flush: ops at edges 0,1, flush at edge 2, new op at edge 3
        put(1'b1, 32'd2, 32'd2, 3'b000, 5'd1);
        step;
        put(1'b1, 32'd3, 32'd3, 3'b000, 5'd2);
        step;
        put(1'b1, 32'd4, 32'd4, 3'b000, 5'd3);
        flush = 1'b1;
        step;
        flush = 1'b0;
        chk("flush_e2_valid", 32'(w_valid), 32'h0);
        chk("flush_e2_busy", 32'(busy), 32'h0);
        put(1'b1, 32'd5, 32'd5, 3'b000, 5'd21);
        step;
        put(1'b0, '0, '0, 3'b000, '0);
        chk("flush_e3_valid", 32'(w_valid), 32'h0);
        step;
        chk("flush_e4_valid", 32'(w_valid), 32'h0);
        step;
        chk("flush_e5_valid", 32'(w_valid), 32'h1);
        chk("flush_e5_rd", w_rd, 32'd25);
        chk("flush_e5_tag", 32'(w_tag), 32'd21);
        step;

        // flush together with stall still empties the pipe
        put(1'b1, 32'd6, 32'd6, 3'b000, 5'd22);
        step;
        put(1'b1, 32'd7, 32'd7, 3'b000, 5'd23);
        stall = 1'b1;
        flush = 1'b1;
        step;
        stall = 1'b0;
        flush = 1'b0;
        put(1'b0, '0, '0, 3'b000, '0);
        chk("fs_busy", 32'(busy), 32'h0);
        for (int e = 0; e < 3; e++) begin
            step;
            chk($sformatf("fs_tail%0d_valid", e), 32'(w_valid), 32'h0);
        end

        // asynchronous reset with a result on the output
        put(1'b1, 32'h10, 32'h10, 3'b000, 5'd3);
        step;
        put(1'b1, 32'h20, 32'h20, 3'b000, 5'd4);
        step;
        put(1'b0, '0, '0, 3'b000, '0);
        step;
        chk("pre_rst_valid", 32'(w_valid), 32'h1);
        chk("pre_rst_rd", w_rd, 32'h100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(w_valid), 32'h0);
        chk("arst_rd", w_rd, 32'h0);
        chk("arst_tag", 32'(w_tag), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        #2;
        rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step;
            chk($sformatf("post_rst%0d_valid", e), 32'(w_valid), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
